vp_gfx_fetch: RTL
=================

# vp_gfx_fetch

Per-scanline fetch controller for the graphics attribute path of the video pipeline. On each line start it reads up to COLUMNS 32-bit graphics records from memory through a single-outstanding req/ready/valid read port. It buffers them in a small prefetch FIFO. On each cell strobe it presents one record as foreground, background, bitmap and enabled to the downstream graphics delay stage.

## Interface

- COLUMNS, 80: cells fetched per line
- FIFO_DEPTH, 4: prefetch entries, power of two, ≥2
- ADDR_WIDTH, 23: memory word-address width

- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low; 0 resets all state
- line_start  in  1  one-cycle pulse; starts a new line
- line_base  in  ADDR_WIDTH  address of the line's first record, sampled on line_start
- line_enable  in  1  sampled on line_start; 0 = line has no graphics, no fetches
- cell_strobe  in  1  one-cycle pulse; consume one cell
- mem_request  out  1  read request
- mem_address  out  ADDR_WIDTH  read address, stable while mem_request=1
- mem_ready  in  1  request accepted this cycle
- mem_data  in  32  read data: [15:0] bitmap, [19:16] foreground, [23:20] background, [24] enabled, [31:25] ignored
- mem_data_valid  in  1  mem_data valid this cycle
- foreground  out  4
- background  out  4
- bitmap  out  16
- enabled  out  1
- underrun  out  1  sticky; strobe hit empty FIFO this line
- busy  out  1  fetch FSM not IDLE

## Operation

- Reset: all outputs 0 (enabled=FALSE, underrun=0, mem_request=0); FSM IDLE; FIFO empty; column counter 0.
- The FSM has four states: IDLE, REQUEST, WAIT, FLUSH.
- IDLE -> REQUEST when the line is active, column < COLUMNS, and fifo_count + outstanding < FIFO_DEPTH.
- REQUEST: mem_request=1, mem_address = line_base + column, modulo 2^ADDR_WIDTH.
  - On mem_ready: column increments, go to WAIT.
- WAIT: on mem_data_valid, push mem_data into the FIFO.
  - Go to REQUEST if the REQUEST condition still holds, else IDLE.
- At most one read is outstanding at any time.
- line_start, in every state:
  - Clears the FIFO, column and underrun.
  - Samples line_base and line_enable.
  - Zeroes foreground, background, bitmap and enabled.
- line_start in REQUEST without mem_ready the same cycle: the request is abandoned and mem_request drops next cycle.
- line_start in REQUEST with mem_ready the same cycle, or in WAIT: go to FLUSH.
  - FLUSH discards the next mem_data_valid beat, then resumes as a fresh line (IDLE/REQUEST).
- line_enable=0: no requests for the line; strobes output zeros with enabled=FALSE, and underrun is not set.
- cell_strobe with FIFO non-empty: pop the head and register its fields onto the outputs.
- cell_strobe with FIFO empty on an enabled line: outputs zeroed, enabled=FALSE, underrun=1 until the next line_start.
- Push and pop in the same cycle: count unchanged; a pop from an empty FIFO never returns the same-cycle push.
- line_start and cell_strobe in the same cycle: line_start wins and the strobe is ignored.
- Strobes beyond COLUMNS on a line behave as an empty FIFO (underrun).
- The FIFO never overflows, by construction of the issue condition.

## Timing

- Output latency: cell_strobe at cycle N -> outputs valid at N+1, held until the next strobe or line_start.
- mem_data_valid at cycle N -> entry poppable at N+1.
- line_start at N -> first mem_request at N+1 at the earliest (from IDLE, line enabled).
- Request-to-request spacing: at least 2 cycles (REQUEST, WAIT) plus memory latency.
- underrun rises the cycle after the offending strobe.

## Structure

- Shared include gfx_record.v holds the record field positions (BITMAP, FG, BG, ENABLED slices) as localparams; TRUE/FALSE come from constant.v.
- FSM state encodings are localparams in the module.
- Natural sub-module: vp_gfx_fifo, a synchronous FIFO with asynchronous active-low reset.
  - Parameters: WIDTH=25, DEPTH.
  - Ports: push, pop, clear, data in/out, count, empty, full.
- The controller instantiates one vp_gfx_fifo.

## Test plan

- Basic fill: line_start with line_base=0x000100, enable=1, mem_ready=1, data returned 2 cycles after accept.
  - Required: addresses 0x100..0x103 requested, then a stall at FIFO_DEPTH=4 until the first strobe.
  - Required: strobe outputs match the records' fields in order.
- Underrun: strobe 1 cycle after line_start with memory latency 10.
  - Required: enabled=0, outputs 0, underrun=1 from the next cycle; a second line_start clears underrun.
- Mid-read restart: line_start while in WAIT.
  - Required: the next mem_data_valid beat is discarded, then fetch restarts at the new line_base; no stale record is ever output.
- Abandon: line_start in REQUEST with mem_ready=0.
  - Required: mem_request drops, no FLUSH, the new line's first address is issued.
- Wrap and limits: line_base=2^23−2 with COLUMNS=4.
  - Required: addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
  - Required: exactly 4 requests; the 5th strobe sets underrun.
- Reset mid-line: assert reset while in WAIT.
  - Required: all outputs 0 immediately; after release, mem_request stays 0 until a line_start.

Source files
------------

// File: rtl/vp_gfx_fetch_pkg.sv
// Shared types and constants for the graphics attribute fetch path.
// Record layout mirrors mem_data[24:0]: enabled, background, foreground, bitmap.
package vp_gfx_fetch_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REC_W  = 25;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef struct packed {
    logic        enabled;   // [24]
    logic [3:0]  bg;        // [23:20]
    logic [3:0]  fg;        // [19:16]
    logic [15:0] bitmap;    // [15:0]
  } gfx_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_WAIT    = 2'd2,
    ST_FLUSH   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/vp_gfx_fifo.sv
// Show-ahead synchronous FIFO for prefetched graphics records.
// Ports: clk, reset (async active-low), push/din write side, pop/dout_c read
// side (head visible combinationally), clear (synchronous flush), count,
// empty_c, full_c. Push when full is dropped unless a pop frees a slot.
module vp_gfx_fifo
  import vp_gfx_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = REC_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty_c,
  output logic                         full_c
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign dout_c  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vp_gfx_fetch.sv
// Per-scanline graphics record fetch controller.
// Ports: clk, reset (async active-low); line_start/line_base/line_enable start
// a line; cell_strobe consumes one cell; mem_request/mem_address/mem_ready and
// mem_data/mem_data_valid form a single-outstanding read port; foreground,
// background, bitmap, enabled present the current cell; underrun is sticky per
// line; busy is high while the fetch FSM is not idle.
module vp_gfx_fetch
  import vp_gfx_fetch_pkg::*;
#(
  parameter int unsigned COLUMNS    = 80,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  input  logic [ADDR_WIDTH-1:0] line_base,
  input  logic                  line_enable,
  input  logic                  cell_strobe,
  output logic                  mem_request,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  mem_data_valid,
  output logic [3:0]            foreground,
  output logic [3:0]            background,
  output logic [15:0]           bitmap,
  output logic                  enabled,
  output logic                  underrun,
  output logic                  busy
);

  localparam int unsigned COL_W = $clog2(COLUMNS + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_X = CNT_W + 1;

  fetch_state_t          state, state_n;
  logic                  line_active;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [COL_W-1:0]      column, column_n;
  logic                  fifo_push, fifo_pop, fifo_empty_c, fifo_full_unused;
  logic [CNT_W-1:0]      fifo_count;
  gfx_rec_t              fifo_dout_c;
  logic [CNT_X-1:0]      count_after;
  logic                  issue_ok;
  logic                  mem_data_unused;

  assign mem_data_unused = ^mem_data[DATA_W-1:REC_W];

  // A beat is only kept in WAIT; beats landing in FLUSH belong to a dead line.
  assign fifo_push   = (state == ST_WAIT) && mem_data_valid && !line_start;
  assign fifo_pop    = cell_strobe && !line_start && !fifo_empty_c;
  assign count_after = CNT_X'(fifo_count) + CNT_X'(fifo_push) - CNT_X'(fifo_pop);
  // Evaluated only when nothing is outstanding, so occupancy after this cycle bounds the FIFO.
  assign issue_ok    = line_active && (column < COL_W'(COLUMNS))
                       && (count_after < CNT_X'(FIFO_DEPTH));

  vp_gfx_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (line_start),
    .din     (mem_data[REC_W-1:0]),
    .dout_c  (fifo_dout_c),
    .count   (fifo_count),
    .empty_c (fifo_empty_c),
    .full_c  (fifo_full_unused)
  );

  // Next-state and next-address decode.
  always_comb begin
    state_n  = state;
    addr_n   = mem_address;
    column_n = column;
    case (state)
      ST_IDLE: begin
        if (line_start) begin
          if (line_enable) begin
            state_n = ST_REQUEST;
            addr_n  = line_base;
          end
        end else if (issue_ok) begin
          state_n = ST_REQUEST;
          addr_n  = base_q + ADDR_WIDTH'(column);
        end
      end
      ST_REQUEST: begin
        if (mem_ready) begin
          column_n = column + COL_W'(1);
          state_n  = line_start ? ST_FLUSH : ST_WAIT;
        end else if (line_start) begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT, ST_FLUSH: begin
        if (mem_data_valid) begin
          if (line_start) begin
            state_n = line_enable ? ST_REQUEST : ST_IDLE;
            addr_n  = line_base;
          end else if (issue_ok) begin
            state_n = ST_REQUEST;
            addr_n  = base_q + ADDR_WIDTH'(column);
          end else begin
            state_n = ST_IDLE;
          end
        end else if (line_start) begin
          state_n = ST_FLUSH;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (line_start) column_n = '0;
  end

  // State, port and cell output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      column      <= '0;
      line_active <= FALSE;
      base_q      <= '0;
      mem_request <= 1'b0;
      mem_address <= '0;
      busy        <= 1'b0;
      foreground  <= '0;
      background  <= '0;
      bitmap      <= '0;
      enabled     <= FALSE;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      column      <= column_n;
      mem_request <= (state_n == ST_REQUEST);
      mem_address <= addr_n;
      busy        <= (state_n != ST_IDLE);
      if (line_start) begin
        line_active <= line_enable;
        base_q      <= line_base;
        foreground  <= '0;
        background  <= '0;
        bitmap      <= '0;
        enabled     <= FALSE;
        underrun    <= 1'b0;
      end else if (cell_strobe) begin
        if (!fifo_empty_c) begin
          foreground <= fifo_dout_c.fg;
          background <= fifo_dout_c.bg;
          bitmap     <= fifo_dout_c.bitmap;
          enabled    <= fifo_dout_c.enabled;
        end else begin
          foreground <= '0;
          background <= '0;
          bitmap     <= '0;
          enabled    <= FALSE;
          if (line_active) underrun <= 1'b1;
        end
      end
    end
  end

endmodule
